skid_fifo: RTL and testbench
============================

# skid_fifo

Parametrised successor to the two-entry skid buffer: a DEPTH-entry, DATA_WIDTH-wide ready/valid stream buffer with fully registered handshake outputs, a synchronous flush, and optional occupancy reporting. It sits between AXI-Stream-style producer and consumer stages to break the combinational paths on both valid/data and ready. It also absorbs bursts of up to DEPTH beats while the consumer stalls. It is checked against the same generic stream master/slave property monitors as the existing skid buffer.

## Interface
- DATA_WIDTH, 8, payload width in bits, ≥1
- DEPTH, 4, storage entries; power of two, ≥2
- ALMOST_FULL_THRESH, DEPTH-1, level at or above which almost_full asserts (only used with SKID_FIFO_LEVEL_EN)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous discard of all stored beats
- in_data  in  DATA_WIDTH  upstream payload
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_data  out  DATA_WIDTH  downstream payload
- out_valid  out  1  downstream valid
- out_ready  in  1  downstream ready
- level  out  $clog2(DEPTH+1)  stored beat count (SKID_FIFO_LEVEL_EN only)
- almost_full  out  1  level ≥ ALMOST_FULL_THRESH (SKID_FIFO_LEVEL_EN only)

## Operation
- Circular buffer: wr_ptr, rd_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH; count is $clog2(DEPTH+1) bits.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- push writes in_data to mem[wr_ptr], wr_ptr+1. pop advances rd_ptr+1.
- count update: push only +1; pop only -1; both or neither unchanged.
- in_ready = !reset && count != DEPTH; out_valid = count != 0; out_data = mem[rd_ptr].
- All three outputs derive only from registers, plus reset gating on in_ready. There is no combinational path from in_* to out_* or from out_ready to in_ready.
- Full: in_ready=0. No push occurs even if a pop happens the same cycle. in_ready rises the cycle after the pop.
- Empty: out_valid=0. A beat pushed into an empty buffer is not visible until the next cycle; there is no bypass.
- Simultaneous push and pop at any count 1..DEPTH-1: both occur, count holds, and order is preserved.
- flush: next edge sets count=0 and wr_ptr=rd_ptr=0. A push or pop in the flush cycle is discarded. Memory contents are unchanged.
- Ordering: strict FIFO. No beat is duplicated, dropped (except by flush or reset), or reordered.
- out_valid, once high, stays high with out_data stable until pop (stream stability rule). flush and reset are the only exceptions.

## Timing
- Reset (mid-operation included): next edge sets count=0, pointers=0, all mem entries=0.
- While reset is high: in_ready=0. After reset: out_valid=0, out_data=0, and in_ready=1 from the first cycle reset is low.
- Latency: a beat accepted at edge N is presented with out_valid=1 in cycle N+1. Minimum throughput is 1 beat/cycle in steady state for count in 1..DEPTH-1.
- in_ready reacts to a pop one cycle later. A full buffer with out_ready held high sustains 1 beat/cycle only once count < DEPTH. DEPTH≥2 guarantees 1 beat/cycle under continuous flow.
- out_valid never asserts before the first accepted in_valid after reset.

## Configuration
- Macro SKID_FIFO_LEVEL_EN.
- Defined: level and almost_full ports exist. Both are registered-derived, reset to 0, and change on the same edge as count. flush clears them.
- Undefined: neither port exists. ALMOST_FULL_THRESH is ignored. Datapath behaviour is identical.

## Structure
- Shared package stream_utils_pkg holds:
  - the ptr-width and count-width helper functions ($clog2-based)
  - the parameter-check constants: DEPTH power of two and ≥2, ALMOST_FULL_THRESH in 1..DEPTH
- One sub-module, skid_fifo_ptr: owns wr_ptr, rd_ptr and count, plus the full/empty flags. It takes push, pop and flush. The top level holds mem and the handshake gating.
- The formal bench reuses the rx/tx counter scheme: at all times rx_count - tx_count == count, and that difference is never above DEPTH.

## Test plan
- Fill/drain: DEPTH=4, out_ready=0, push 0x11..0x44 → in_ready=0 after the 4th beat. Then out_ready=1 → out_data 0x11,0x22,0x33,0x44 on consecutive cycles, then out_valid=0.
- Full with simultaneous demand: full, in_valid=1 and out_ready=1 for one cycle → exactly one pop, no push, count=3, in_ready=1 the next cycle.
- Streaming: in_valid=out_ready=1 for 20 cycles with an incrementing payload → 19 beats out in order, 1-cycle latency, no bubbles.
- Flush: 3 beats stored, flush=1 with in_valid=1 → the next cycle count=0, out_valid=0, in_ready=1, the flush-cycle beat is lost, and the next pushed 0xA5 emerges first.
- Reset mid-burst: reset at count=2 → the next cycle out_valid=0, out_data=0, in_ready=0 while held. After release, in_ready=1 and level=0.
- Level (SKID_FIFO_LEVEL_EN, THRESH=3): push 3 beats, no pops → level=3 and almost_full=1 the cycle after the third push. One pop → level=2, almost_full=0.

Source files
------------

// File: rtl/stream_utils_pkg.sv
// Shared stream-buffer helpers: pointer/count widths and elaboration-time
// parameter sanity checks used by the skid_fifo family.
package stream_utils_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int thresh, input int depth);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/skid_fifo_ptr.sv
// Pointer/occupancy tracker for skid_fifo: wrapping read/write pointers,
// beat count and registered full/empty flags; flush and reset zero everything.
module skid_fifo_ptr
  import stream_utils_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic [ptr_width(DEPTH)-1:0]   wr_ptr_o,
  output logic [ptr_width(DEPTH)-1:0]   rd_ptr_o,
  output logic [count_width(DEPTH)-1:0] count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are registered from next-state count so the handshake outputs
  // never see a comparator on their path.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/skid_fifo.sv
// DEPTH-entry registered ready/valid stream buffer with synchronous flush.
// Optional level/almost_full ports are enabled with macro SKID_FIFO_LEVEL_EN.
module skid_fifo
  import stream_utils_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 4,
  parameter int ALMOST_FULL_THRESH = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef SKID_FIFO_LEVEL_EN
  ,
  output logic [count_width(DEPTH)-1:0] level,
  output logic                          almost_full
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("skid_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!thresh_ok(ALMOST_FULL_THRESH, DEPTH)) begin : g_bad_thresh
    $error("skid_fifo: ALMOST_FULL_THRESH must lie in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, empty;
  logic                  push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  skid_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  // A flush-cycle beat is dropped without touching storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  assign in_ready  = !reset && !full;
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr];

`ifdef SKID_FIFO_LEVEL_EN
  assign level       = count;
  assign almost_full = (count >= CW'(ALMOST_FULL_THRESH));
`else
  logic unused_count;
  assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Directed and randomized checks of skid_fifo against a queue-based model.
module tb_skid_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int THR   = DEPTH - 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
`ifdef SKID_FIFO_LEVEL_EN
  logic [2:0]    level;
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  skid_fifo #(
    .DATA_WIDTH         (DW),
    .DEPTH              (DEPTH),
    .ALMOST_FULL_THRESH (THR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef SKID_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] q[$];
  int            pops = 0;
  bit            zero_data = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check ready gating, advance model, check outputs.
  task automatic cycle(input bit rst, input bit fl, input bit iv,
                       input logic [DW-1:0] d, input bit ordy);
    bit exp_rdy, do_push, do_pop;
    reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    exp_rdy = !rst && (q.size() != DEPTH);
    #1;
    chk("in_ready_pre", {31'b0, in_ready}, {31'b0, exp_rdy});
    do_push = iv && exp_rdy;
    do_pop  = (q.size() != 0) && ordy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      zero_data = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (do_push) begin
        q.push_back(d);
        zero_data = 1'b0;
      end
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) chk("out_data", {24'b0, out_data}, {24'b0, q[0]});
    else if (zero_data) chk("out_data_zero", {24'b0, out_data}, 32'h0);
    chk("in_ready", {31'b0, in_ready}, {31'b0, !rst && (q.size() != DEPTH)});
`ifdef SKID_FIFO_LEVEL_EN
    chk("level", {29'b0, level}, q.size());
    chk("almost_full", {31'b0, almost_full}, {31'b0, q.size() >= THR});
`endif
  endtask

  initial begin
    // Reset
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);

    // Fill with consumer stalled, then a rejected beat while full
    cycle(0, 0, 1, 8'h11, 0);
    cycle(0, 0, 1, 8'h22, 0);
    cycle(0, 0, 1, 8'h33, 0);
    cycle(0, 0, 1, 8'h44, 0);
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    cycle(0, 0, 1, 8'h55, 0);

    // Drain back-to-back
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 8'h00, 1);
    chk("drained_valid", {31'b0, out_valid}, 32'h0);

    // Full with simultaneous demand: one pop, no push
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h80 + 8'(i), 0);
    cycle(0, 0, 1, 8'h66, 1);
    chk("full_demand_ready", {31'b0, in_ready}, 32'h1);
    chk("full_demand_head", {24'b0, out_data}, 32'h81);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 8'h00, 1);

    // Streaming: 20 cycles of continuous flow from empty
    pops = 0;
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 8'(i + 1), 1);
    chk("stream_pops", pops, 19);
    cycle(0, 0, 0, 8'h00, 1);

    // Flush with a beat offered in the flush cycle
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'hC0 + 8'(i), 0);
    cycle(0, 1, 1, 8'hEE, 1);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    cycle(0, 0, 1, 8'hA5, 0);
    chk("flush_next_head", {24'b0, out_data}, 32'hA5);
    cycle(0, 0, 0, 8'h00, 1);

    // Reset mid-burst at two stored beats
    cycle(0, 0, 1, 8'h71, 0);
    cycle(0, 0, 1, 8'h72, 0);
    cycle(1, 0, 1, 8'h77, 1);
    cycle(1, 0, 1, 8'h78, 1);
    chk("rst_out_data", {24'b0, out_data}, 32'h0);
    cycle(0, 0, 0, 8'h00, 0);

`ifdef SKID_FIFO_LEVEL_EN
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h30 + 8'(i), 0);
    chk("lvl3", {29'b0, level}, 32'd3);
    chk("af3", {31'b0, almost_full}, 32'h1);
    cycle(0, 0, 0, 8'h00, 1);
    chk("lvl2", {29'b0, level}, 32'd2);
    chk("af2", {31'b0, almost_full}, 32'h0);
    cycle(0, 1, 0, 8'h00, 0);
`endif

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
